// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

  // Arbiter FSM encoding; the values are part of the debug interface.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_e;

  // One UART frame: start bit, 8 data bits, stop bit.
  localparam int FRAME_BITS = 10;

  typedef logic [7:0] byte_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first set request after last_grant,
// wrapping modulo N_REQ. Usable by any shared-resource arbiter.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last_grant,
  output logic [IW-1:0]    winner,
  output logic             any_req
);

  logic [IW-1:0] idx;

  // Scan from the farthest offset down to +1 so the nearest requester wins.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = IW'((int'(last_grant) + k) % N_REQ);
      if (req[idx]) begin
        winner  = idx;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter between N_REQ producers.
// Handshake: a requester holds req_valid and its byte until req_ready; the
// byte is consumed on the single cycle where req_valid & req_ready are high.
// Frame sequence: grant (IDLE) -> start strobe (START) -> wait for uart_done
// or watchdog (WAIT_DONE) -> IDLE.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int CLK_PER_BAUD = 4,
  parameter int TIMEOUT_CLKS = 12 * CLK_PER_BAUD,
  parameter int IW           = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_byte,
  output logic [N_REQ-1:0]     req_ready,
  output logic [7:0]           uart_tx_byte,
  output logic                 uart_start_send,
  input  logic                 uart_done,
  output logic [IW-1:0]        grant_id,
  output logic                 busy,
  output logic                 timeout_err,
  output logic [1:0]           state_dbg
);

  // The watchdog must never cut a legal frame short, so its limit is clamped
  // to at least one clock past a full frame.
  localparam int WD_MIN   = FRAME_BITS * CLK_PER_BAUD + 1;
  localparam int WD_LIMIT = (TIMEOUT_CLKS > WD_MIN) ? TIMEOUT_CLKS : WD_MIN;
  localparam int WDW      = $clog2(WD_LIMIT);
  localparam logic [WDW-1:0] WD_LAST = WDW'(WD_LIMIT - 1);

  localparam logic [1:0] S_IDLE      = ST_IDLE;
  localparam logic [1:0] S_START     = ST_START;
  localparam logic [1:0] S_WAIT_DONE = ST_WAIT_DONE;

  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  logic [1:0]     state;
  logic [IW-1:0]  last_grant;
  logic [WDW-1:0] wd_cnt;
  logic [IW-1:0]  winner;
  logic           any_req;
  byte_t          req_bytes [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_bytes
    assign req_bytes[i] = req_byte[8*i +: 8];
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr_pick (
    .req        (req_valid),
    .last_grant (last_grant),
    .winner     (winner),
    .any_req    (any_req)
  );

  assign state_dbg = state;

  // Arbiter FSM with registered outputs and WAIT_DONE watchdog.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= S_IDLE;
      last_grant      <= IW'(N_REQ - 1);
      wd_cnt          <= '0;
      req_ready       <= '0;
      uart_tx_byte    <= 8'h00;
      uart_start_send <= 1'b0;
      grant_id        <= '0;
      busy            <= 1'b0;
      timeout_err     <= 1'b0;
    end else begin
      req_ready       <= '0;
      uart_start_send <= 1'b0;
      timeout_err     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            req_ready    <= ONE_HOT0 << winner;
            uart_tx_byte <= req_bytes[winner];
            grant_id     <= winner;
            last_grant   <= winner;
            busy         <= 1'b1;
            state        <= S_START;
          end
        end
        S_START: begin
          uart_start_send <= 1'b1;
          wd_cnt          <= '0;
          state           <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          // Completion wins over a watchdog expiry on the same cycle.
          if (uart_done) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (wd_cnt == WD_LAST) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter; the bench plays the requesters and the UART.
module tb_uart_tx_arbiter;

  localparam logic [1:0] ST_I = 2'd0;
  localparam logic [1:0] ST_S = 2'd1;
  localparam logic [1:0] ST_W = 2'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_byte;
  logic [3:0]  req_ready;
  logic [7:0]  uart_tx_byte;
  logic        uart_start_send;
  logic        uart_done;
  logic [1:0]  grant_id;
  logic        busy;
  logic        timeout_err;
  logic [1:0]  state_dbg;

  int errors = 0;
  int checks = 0;

  uart_tx_arbiter #(
    .N_REQ        (4),
    .CLK_PER_BAUD (4),
    .TIMEOUT_CLKS (48)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_byte        (req_byte),
    .req_ready       (req_ready),
    .uart_tx_byte    (uart_tx_byte),
    .uart_start_send (uart_start_send),
    .uart_done       (uart_done),
    .grant_id        (grant_id),
    .busy            (busy),
    .timeout_err     (timeout_err),
    .state_dbg       (state_dbg)
  );

  // Clock and global time bound.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    rst       = 1'b0;
    req_valid = '0;
    req_byte  = '0;
    uart_done = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Waits (bounded) for a req_ready pulse; returns at the negedge it is seen.
  task automatic wait_grant(input int max, output int lat, output bit found);
    lat   = 0;
    found = 1'b0;
    while (lat < max && !found) begin
      @(negedge clk);
      lat++;
      if (req_ready != 4'b0000) found = 1'b1;
    end
  endtask

  // Called at the first WAIT_DONE negedge; uart_done is high in WAIT_DONE cycle k.
  task automatic uart_frame(input int k);
    repeat (k - 1) @(negedge clk);
    uart_done = 1'b1;
    @(negedge clk);
    uart_done = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; req_valid = '0; req_byte = '0; uart_done = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
    checks++; if (uart_tx_byte !== 8'h00) begin errors++; $display("FAIL reset_tx_byte: got %h expected 00", uart_tx_byte); end
    checks++; if (uart_start_send !== 1'b0) begin errors++; $display("FAIL reset_start: got %b expected 0", uart_start_send); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
    checks++; if (busy !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL reset_busy_to: got %b%b expected 00", busy, timeout_err); end
    checks++; if (state_dbg !== ST_I) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, ST_I); end
    rst = 1'b1;
  endtask

  task automatic test_single();
    int lat; bit found;
    apply_reset();
    req_byte[23:16] = 8'h41;
    req_valid = 4'b0100;
    wait_grant(8, lat, found);
    checks++; if (!found || lat != 1) begin errors++; $display("FAIL single_latency: got found=%0d lat=%0d expected found=1 lat=1", found, lat); end
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b expected 0100", req_ready); end
    checks++; if (grant_id !== 2'd2 || busy !== 1'b1) begin errors++; $display("FAIL single_gid_busy: got gid=%0d busy=%b expected gid=2 busy=1", grant_id, busy); end
    checks++; if (uart_start_send !== 1'b0 || state_dbg !== ST_S) begin errors++; $display("FAIL single_start_early: got start=%b state=%0d expected start=0 state=1", uart_start_send, state_dbg); end
    req_valid = 4'b0000;
    @(negedge clk);
    checks++; if (uart_start_send !== 1'b1 || uart_tx_byte !== 8'h41) begin errors++; $display("FAIL single_start: got start=%b byte=%h expected start=1 byte=41", uart_start_send, uart_tx_byte); end
    checks++; if (req_ready !== 4'b0000 || state_dbg !== ST_W) begin errors++; $display("FAIL single_wait: got ready=%b state=%0d expected ready=0000 state=2", req_ready, state_dbg); end
    @(negedge clk);
    checks++; if (uart_start_send !== 1'b0) begin errors++; $display("FAIL single_strobe_width: got %b expected 0", uart_start_send); end
    uart_frame(39);
    checks++; if (busy !== 1'b0 || state_dbg !== ST_I || timeout_err !== 1'b0) begin errors++; $display("FAIL single_done: got busy=%b state=%0d to=%b expected busy=0 state=0 to=0", busy, state_dbg, timeout_err); end
    @(negedge clk);
    checks++; if (req_ready !== 4'b0000 || state_dbg !== ST_I) begin errors++; $display("FAIL single_no_regrant: got ready=%b state=%0d expected ready=0000 state=0", req_ready, state_dbg); end
  endtask

  task automatic test_round_robin();
    int lat; bit found;
    logic [1:0] exp_id;
    logic [3:0] exp_rdy;
    logic [7:0] exp_byte;
    apply_reset();
    req_byte  = {8'h44, 8'h43, 8'h42, 8'h41};
    req_valid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      exp_id   = 2'(g % 4);
      exp_rdy  = 4'b0001 << exp_id;
      exp_byte = 8'h41 + 8'(exp_id);
      wait_grant(8, lat, found);
      checks++; if (!found) begin errors++; $display("FAIL rr_grant_timeout: got no grant expected grant %0d", exp_id); end
      checks++; if (lat != 1) begin errors++; $display("FAIL rr_gap: got %0d non-frame cycles expected 2", lat + 1); end
      checks++; if (grant_id !== exp_id || req_ready !== exp_rdy) begin errors++; $display("FAIL rr_order: got gid=%0d ready=%b expected gid=%0d ready=%b", grant_id, req_ready, exp_id, exp_rdy); end
      @(negedge clk);
      checks++; if (uart_start_send !== 1'b1 || uart_tx_byte !== exp_byte) begin errors++; $display("FAIL rr_start: got start=%b byte=%h expected start=1 byte=%h", uart_start_send, uart_tx_byte, exp_byte); end
      uart_frame(40);
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_priority();
    int lat; bit found;
    apply_reset();
    req_byte  = {8'h13, 8'h00, 8'h00, 8'h10};
    req_valid = 4'b1001;
    wait_grant(8, lat, found);
    checks++; if (!found || req_ready !== 4'b0001 || grant_id !== 2'd0) begin errors++; $display("FAIL prio_first: got ready=%b gid=%0d expected ready=0001 gid=0", req_ready, grant_id); end
    req_valid = 4'b1000;
    @(negedge clk);
    uart_frame(20);
    wait_grant(8, lat, found);
    checks++; if (!found || req_ready !== 4'b1000 || grant_id !== 2'd3) begin errors++; $display("FAIL prio_second: got ready=%b gid=%0d expected ready=1000 gid=3", req_ready, grant_id); end
    req_valid = 4'b0000;
    @(negedge clk);
    checks++; if (uart_tx_byte !== 8'h13) begin errors++; $display("FAIL prio_byte: got %h expected 13", uart_tx_byte); end
    uart_frame(20);
  endtask

  task automatic test_watchdog();
    int lat; bit found; int bad;
    apply_reset();
    req_byte[15:8] = 8'h5A;
    req_valid = 4'b0010;
    wait_grant(8, lat, found);
    req_valid = 4'b0000;
    @(negedge clk);
    bad = 0;
    repeat (47) begin
      @(negedge clk);
      if (timeout_err !== 1'b0 || state_dbg !== ST_W) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL wd_early: got %0d bad cycles before cycle 48 expected 0", bad); end
    @(negedge clk);
    checks++; if (timeout_err !== 1'b1 || state_dbg !== ST_I || busy !== 1'b0) begin errors++; $display("FAIL wd_abort: got to=%b state=%0d busy=%b expected to=1 state=0 busy=0", timeout_err, state_dbg, busy); end
    req_byte[23:16] = 8'h77;
    req_valid = 4'b0100;
    @(negedge clk);
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL wd_pulse_width: got %b expected 0", timeout_err); end
    checks++; if (req_ready !== 4'b0100 || grant_id !== 2'd2) begin errors++; $display("FAIL wd_regrant: got ready=%b gid=%0d expected ready=0100 gid=2", req_ready, grant_id); end
    req_valid = 4'b0000;
    @(negedge clk);
    checks++; if (uart_start_send !== 1'b1 || uart_tx_byte !== 8'h77) begin errors++; $display("FAIL wd_next_start: got start=%b byte=%h expected start=1 byte=77", uart_start_send, uart_tx_byte); end
    uart_frame(40);
    checks++; if (state_dbg !== ST_I || timeout_err !== 1'b0) begin errors++; $display("FAIL wd_next_done: got state=%0d to=%b expected state=0 to=0", state_dbg, timeout_err); end
  endtask

  task automatic test_reset_mid_frame();
    int lat; bit found; int bad;
    apply_reset();
    req_byte[23:16] = 8'h22;
    req_valid = 4'b0100;
    wait_grant(8, lat, found);
    req_valid = 4'b0000;
    @(negedge clk);
    repeat (9) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0000 || uart_tx_byte !== 8'h00 || uart_start_send !== 1'b0) begin errors++; $display("FAIL mid_rst_out_a: got ready=%b byte=%h start=%b expected 0000 00 0", req_ready, uart_tx_byte, uart_start_send); end
    checks++; if (grant_id !== 2'd0 || busy !== 1'b0 || timeout_err !== 1'b0 || state_dbg !== ST_I) begin errors++; $display("FAIL mid_rst_out_b: got gid=%0d busy=%b to=%b state=%0d expected 0 0 0 0", grant_id, busy, timeout_err, state_dbg); end
    req_byte  = {8'h44, 8'h43, 8'h42, 8'h41};
    req_valid = 4'b1111;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_grant(8, lat, found);
    checks++; if (!found || req_ready !== 4'b0001 || grant_id !== 2'd0) begin errors++; $display("FAIL mid_rst_first: got ready=%b gid=%0d expected ready=0001 gid=0", req_ready, grant_id); end
    req_valid = 4'b0000;
    @(negedge clk);
    checks++; if (uart_start_send !== 1'b1 || uart_tx_byte !== 8'h41) begin errors++; $display("FAIL mid_rst_start: got start=%b byte=%h expected start=1 byte=41", uart_start_send, uart_tx_byte); end
    bad = 0;
    repeat (38) begin
      @(negedge clk);
      if (timeout_err !== 1'b0 || state_dbg !== ST_W) bad++;
    end
    @(negedge clk);
    uart_done = 1'b1;
    @(negedge clk);
    uart_done = 1'b0;
    checks++; if (bad != 0) begin errors++; $display("FAIL mid_rst_spurious: got %0d bad cycles expected 0", bad); end
    checks++; if (state_dbg !== ST_I || timeout_err !== 1'b0) begin errors++; $display("FAIL mid_rst_done: got state=%0d to=%b expected state=0 to=0", state_dbg, timeout_err); end
  endtask

  task automatic test_collision();
    int lat; bit found;
    apply_reset();
    uart_done = 1'b1;
    @(negedge clk);
    uart_done = 1'b0;
    checks++; if (state_dbg !== ST_I || busy !== 1'b0 || uart_start_send !== 1'b0) begin errors++; $display("FAIL idle_done_ignored: got state=%0d busy=%b start=%b expected 0 0 0", state_dbg, busy, uart_start_send); end
    req_byte[31:24] = 8'h5C;
    req_valid = 4'b1000;
    wait_grant(8, lat, found);
    checks++; if (!found || grant_id !== 2'd3) begin errors++; $display("FAIL coll_grant: got found=%0d gid=%0d expected found=1 gid=3", found, grant_id); end
    req_valid = 4'b0000;
    @(negedge clk);
    uart_frame(48);
    checks++; if (state_dbg !== ST_I || timeout_err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL coll_clean: got state=%0d to=%b busy=%b expected 0 0 0", state_dbg, timeout_err, busy); end
    @(negedge clk);
    checks++; if (timeout_err !== 1'b0 || state_dbg !== ST_I) begin errors++; $display("FAIL coll_no_late_to: got to=%b state=%0d expected 0 0", timeout_err, state_dbg); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_priority();
    test_watchdog();
    test_reset_mid_frame();
    test_collision();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
